// File: rtl/mtm_alu_pkg.sv
// ==========================================================================
// Module : mtm_alu_pkg
// Brief  : shared constants, state encoding and helpers for the mtm ALU family
// Rev    : 1.0
// ==========================================================================
`default_nettype none

package mtm_alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    localparam int ERR_DATA_BIT = 2;
    localparam int ERR_CRC_BIT  = 1;
    localparam int ERR_OP_BIT   = 0;

    // start + cmd + payload + stop
    localparam int FRAME_LEN    = 11;
    localparam int PAYLOAD_BITS = FRAME_LEN - 3;

    localparam logic [3:0] CRC_POLY = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_WAIT_HI = 3'd4
    } frame_state_t;

    function automatic logic op_is_valid(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mtm_crc4_serial.sv
// ==========================================================================
// Module : mtm_crc4_serial
// Brief  : bit-serial CRC-4 (x^4+x+1), MSB first, zero seed
// Rev    : 1.0
// ==========================================================================
`default_nettype none

module mtm_crc4_serial
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en,
    input  logic       din,
    output logic [3:0] crc
);
    logic feedback;

    assign feedback = crc[3] ^ din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 4'h0;
        end else if (clear) begin
            crc <= 4'h0;
        end else if (en) begin
            crc <= {crc[2:0], 1'b0} ^ (feedback ? CRC_POLY : 4'h0);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mtm_alu_deserializer_p.sv
// ==========================================================================
// Module : mtm_alu_deserializer_p
// Brief  : serial packet receiver with valid/ready output; MTM_DESER_TIMEOUT_EN adds idle timeout
// Rev    : 1.0
// ==========================================================================
`default_nettype none

module mtm_alu_deserializer_p
    import mtm_alu_pkg::*;
#(
    parameter int OP_W        = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sin,
    output logic [OP_W-1:0] a_out,
    output logic [OP_W-1:0] b_out,
    output logic [2:0]      op_out,
    output logic [2:0]      err_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            ovf
);
    localparam int NBYTES = 2 * OP_W / 8;
    localparam int CNT_W  = $clog2(NBYTES + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NBYTES);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(NBYTES + 1);
    localparam logic [2:0]       LAST_BIT = 3'(PAYLOAD_BITS - 1);

    if ((OP_W % 8) != 0 || OP_W < 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("mtm_alu_deserializer_p: illegal OP_W or TIMEOUT_CYC");
    end

    frame_state_t        state, state_nx;
    logic [2:0]          bit_cnt;
    logic                is_ctl;
    logic [7:0]          shreg;
    logic [CNT_W-1:0]    byte_cnt;
    logic [2*OP_W-1:0]   opnd_sr;
    logic                pkt_bad;
    logic                crc_en, crc_din;
    logic [3:0]          crc;
    logic                ctl_done, pkt_done, timeout;
    logic [2:0]          err_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (!sin) state_nx = ST_CMD;
            ST_CMD:     state_nx = ST_DATA;
            ST_DATA:    if (bit_cnt == LAST_BIT) state_nx = ST_STOP;
            ST_STOP:    state_nx = sin ? ST_IDLE : ST_WAIT_HI;
            ST_WAIT_HI: if (sin) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // CTL frames contribute a constant 1 in place of bit 7, then the opcode bits
    assign crc_en  = (state == ST_DATA) && (!is_ctl || bit_cnt < 3'd4);
    assign crc_din = (is_ctl && bit_cnt == 3'd0) ? 1'b1 : sin;

    mtm_crc4_serial u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (pkt_done),
        .en    (crc_en),
        .din   (crc_din),
        .crc   (crc)
    );

`ifdef MTM_DESER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] idle_cnt;
    logic            idle_armed;

    assign idle_armed = (state == ST_IDLE) && sin && (byte_cnt != '0);
    assign timeout    = idle_armed && (idle_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      idle_cnt <= '0;
        else if (!idle_armed || timeout) idle_cnt <= '0;
        else                             idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    assign ctl_done = (state == ST_STOP) && is_ctl;
    assign pkt_done = ctl_done || timeout;

    always_comb begin
        err_nx = 3'b000;
        if (timeout || byte_cnt != CNT_FULL || pkt_bad || !sin)
            err_nx[ERR_DATA_BIT] = 1'b1;
        else if (crc != shreg[3:0])
            err_nx[ERR_CRC_BIT] = 1'b1;
        else if (shreg[7] || !op_is_valid(shreg[6:4]))
            err_nx[ERR_OP_BIT] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= 3'd0;
            is_ctl    <= 1'b0;
            shreg     <= 8'h00;
            byte_cnt  <= '0;
            opnd_sr   <= '0;
            pkt_bad   <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
            op_out    <= 3'b000;
            err_out   <= 3'b000;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            ovf <= 1'b0;
            case (state)
                ST_CMD: begin
                    is_ctl  <= sin;
                    bit_cnt <= 3'd0;
                end
                ST_DATA: begin
                    shreg   <= {shreg[6:0], sin};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                ST_STOP: begin
                    if (!sin) pkt_bad <= 1'b1;
                    if (!is_ctl) begin
                        if (byte_cnt < CNT_FULL) opnd_sr <= {opnd_sr[2*OP_W-9:0], shreg};
                        if (byte_cnt != CNT_SAT) byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                default: ;
            endcase

            if (pkt_done) begin
                byte_cnt <= '0;
                pkt_bad  <= 1'b0;
            end

            // Operands and opcode only move on a clean packet; errors keep the last good values
            if (pkt_done && (!out_valid || out_ready)) begin
                out_valid <= 1'b1;
                err_out   <= err_nx;
                if (err_nx == 3'b000) begin
                    b_out  <= opnd_sr[2*OP_W-1:OP_W];
                    a_out  <= opnd_sr[OP_W-1:0];
                    op_out <= shreg[6:4];
                end
            end else begin
                if (out_ready) out_valid <= 1'b0;
                if (pkt_done)  ovf <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
